// File: rtl/mire_if.sv
// Wishbone classic master bus bundle for the framebuffer port.
// The master drives the cycle; the slave returns ack.
interface mire_if #(
   parameter int ADR_W = 32
);
   logic [ADR_W-1:0] adr;
   logic [15:0]      dat_ms;
   logic             cyc;
   logic             stb;
   logic             we;
   logic [1:0]       sel;
   logic [2:0]       cti;
   logic [1:0]       bte;
   logic             ack;

   modport master (
      output adr, dat_ms, cyc, stb,
      output we, sel, cti, bte,
      input  ack
   );

   modport slave (
      input  adr, dat_ms, cyc, stb,
      input  we, sel, cti, bte,
      output ack
   );
endinterface

// File: rtl/mire_gen.sv
// Test-pattern generator: writes one RGB565 frame per start
// into the framebuffer as a throttled Wishbone master.
module mire_gen #(
   parameter int          HDISP     = 640,
   parameter int          VDISP     = 480,
   parameter int          GRID      = 16,
   parameter int          GAP       = 63,
   parameter int unsigned BASE_ADDR = 0,
   parameter int          ADR_W     = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [1:0] mode,
   mire_if.master     wshb,
   output logic       busy,
   output logic       frame_done
);
   localparam int LG  = $clog2(GRID);
   localparam int XC  = $clog2(HDISP);
   localparam int YC  = $clog2(VDISP);
   localparam int XW  = (XC > LG) ? XC : LG + 1;
   localparam int YW  = (YC > LG) ? YC : LG + 1;
   localparam int BAR = HDISP / 8;
   localparam int BW  = (BAR > 1) ? $clog2(BAR) : 1;
   localparam int GW  = (GAP > 2) ? $clog2(GAP) : 1;

   localparam logic [XW-1:0] XLAST = XW'(HDISP - 1);
   localparam logic [YW-1:0] YLAST = YW'(VDISP - 1);
   localparam logic [BW-1:0] BLAST = BW'(BAR - 1);
   localparam logic [GW-1:0] GLAST =
      GW'((GAP > 0) ? GAP - 1 : 0);
   localparam logic [ADR_W-1:0] BASE = ADR_W'(BASE_ADDR);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_GAP
   } state_t;

   state_t           state_q, state_d;
   logic [XW-1:0]    x_q, x_d, nx, lx;
   logic [YW-1:0]    y_q, y_d, ny, ly;
   logic [BW-1:0]    bc_q, bc_d, nbc;
   logic [2:0]       bar_q, bar_d, nbar, lbar;
   logic [GW-1:0]    gap_q, gap_d;
   logic [15:0]      fcnt_q, fcnt_d;
   logic [1:0]       mode_q, mode_d, lmode;
   logic [ADR_W-1:0] adr_q, adr_d;
   logic [15:0]      dat_q, dat_d, pix, bar_c;
   logic             done_q, done_d;
   logic             x_last, y_last, b_last;
   logic [LG-1:0]    sx;
   logic             hit;

   assign x_last = (x_q == XLAST);
   assign y_last = (y_q == YLAST);
   assign b_last = (bc_q == BLAST);

   // Coordinates of the pixel that gets loaded this cycle
   always_comb begin
      nx   = x_last ? '0 : x_q + XW'(1);
      ny   = y_q;
      nbc  = bc_q + BW'(1);
      nbar = bar_q;
      if (x_last) begin
         ny   = y_last ? '0 : y_q + YW'(1);
         nbc  = '0;
         nbar = '0;
      end else if (b_last) begin
         nbc  = '0;
         nbar = bar_q + 3'd1;
      end
      lx    = nx;
      ly    = ny;
      lbar  = nbar;
      lmode = mode_q;
      if (state_q == S_IDLE) begin
         lx    = '0;
         ly    = '0;
         lbar  = '0;
         lmode = mode;
      end
   end

   always_comb begin
      sx = lx[LG-1:0] + fcnt_q[LG-1:0];
      case (lbar)
         3'd0:    bar_c = 16'hFFFF;
         3'd1:    bar_c = 16'hFFE0;
         3'd2:    bar_c = 16'h07FF;
         3'd3:    bar_c = 16'h07E0;
         3'd4:    bar_c = 16'hF81F;
         3'd5:    bar_c = 16'hF800;
         3'd6:    bar_c = 16'h001F;
         default: bar_c = 16'h0000;
      endcase
      case (lmode)
         2'd0: hit = (lx[LG-1:0] == '0) ||
                     (ly[LG-1:0] == '0);
         2'd2: hit = lx[LG] ^ ly[LG];
         2'd3: hit = (sx == '0) ||
                     (ly[LG-1:0] == '0);
         default: hit = 1'b0;
      endcase
      pix = (lmode == 2'd1) ? bar_c : {16{hit}};
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      bc_d    = bc_q;
      bar_d   = bar_q;
      gap_d   = gap_q;
      fcnt_d  = fcnt_q;
      mode_d  = mode_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      done_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (enable) begin
               mode_d  = mode;
               x_d     = '0;
               y_d     = '0;
               bc_d    = '0;
               bar_d   = '0;
               adr_d   = BASE;
               dat_d   = pix;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (wshb.ack) begin
               if (x_last && y_last) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                  fcnt_d  = fcnt_q + 16'd1;
                  x_d     = '0;
                  y_d     = '0;
                  bc_d    = '0;
                  bar_d   = '0;
                  adr_d   = BASE;
               end else begin
                  x_d   = nx;
                  y_d   = ny;
                  bc_d  = nbc;
                  bar_d = nbar;
                  adr_d = adr_q + ADR_W'(2);
                  dat_d = pix;
                  if (GAP > 0) begin
                     state_d = S_GAP;
                     gap_d   = '0;
                  end
               end
            end
         end
         S_GAP: begin
            if (gap_q == GLAST) state_d = S_REQ;
            else gap_d = gap_q + GW'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         bc_q    <= '0;
         bar_q   <= '0;
         gap_q   <= '0;
         fcnt_q  <= '0;
         mode_q  <= '0;
         adr_q   <= BASE;
         dat_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         bc_q    <= bc_d;
         bar_q   <= bar_d;
         gap_q   <= gap_d;
         fcnt_q  <= fcnt_d;
         mode_q  <= mode_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         done_q  <= done_d;
      end
   end

   // Strobe straight from state so reset drops it at once
   assign wshb.cyc    = (state_q == S_REQ);
   assign wshb.stb    = (state_q == S_REQ);
   assign wshb.we     = 1'b1;
   assign wshb.sel    = 2'b11;
   assign wshb.cti    = 3'd0;
   assign wshb.bte    = 2'd0;
   assign wshb.adr    = adr_q;
   assign wshb.dat_ms = dat_q;
   assign busy        = (state_q != S_IDLE);
   assign frame_done  = done_q;
endmodule

// File: tb/tb_mire_gen.sv
// Scoreboard bench for mire_gen: a reference model queues
// expected writes, a bus monitor acks and checks them.
module tb_mire_gen;
   localparam int H    = 8;
   localparam int V    = 4;
   localparam int G    = 4;
   localparam int BASE = 'h100;

   typedef struct {
      logic [31:0] adr;
      logic [15:0] dat;
      bit          last;
   } txn_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en, en0;
   logic [1:0] mode, mode0;
   logic       busy, fd, busy0, fd0;

   always #5 clk = ~clk;

   mire_if #(.ADR_W(32)) bus ();
   mire_if #(.ADR_W(32)) bus0 ();

   mire_gen #(
      .HDISP(H), .VDISP(V), .GRID(G), .GAP(3),
      .BASE_ADDR(BASE), .ADR_W(32)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(en),
      .mode(mode), .wshb(bus.master),
      .busy(busy), .frame_done(fd)
   );

   mire_gen #(
      .HDISP(H), .VDISP(V), .GRID(G), .GAP(0),
      .BASE_ADDR(BASE), .ADR_W(32)
   ) dut0 (
      .clk(clk), .rst_n(rst_n), .enable(en0),
      .mode(mode0), .wshb(bus0.master),
      .busy(busy0), .frame_done(fd0)
   );

   assign bus0.ack = 1'b1;

   int   n_cmp = 0;
   int   n_bad = 0;
   txn_t q[$];

   task automatic check(input string nm,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h",
                  nm, act, exp);
      end
   endtask

   function automatic logic [15:0] ref_pix(
      input int m, input int x, input int y, input int fc);
      logic w;
      case (m)
         0: w = (x % G == 0) || (y % G == 0);
         2: w = ((x / G) % 2) != ((y / G) % 2);
         3: w = ((x + fc) % G == 0) || (y % G == 0);
         default: begin
            case (x / (H / 8))
               0: return 16'hFFFF;
               1: return 16'hFFE0;
               2: return 16'h07FF;
               3: return 16'h07E0;
               4: return 16'hF81F;
               5: return 16'hF800;
               6: return 16'h001F;
               default: return 16'h0000;
            endcase
         end
      endcase
      return w ? 16'hFFFF : 16'h0000;
   endfunction

   task automatic push_frame(input int m, input int fc);
      txn_t t;
      for (int y = 0; y < V; y++)
         for (int x = 0; x < H; x++) begin
            t.adr  = BASE + 2 * (H * y + x);
            t.dat  = ref_pix(m, x, y, fc);
            t.last = (x == H - 1) && (y == V - 1);
            q.push_back(t);
         end
   endtask

   // Monitor / slave state
   bit          mon_en = 0;
   int          dly_mode = 0;
   int          want = 0, waitc = 0;
   logic [31:0] hold_adr;
   logic [15:0] hold_dat;
   bit          exp_fd = 0, chk_b2b = 0;
   bit          prev_stb = 0, period_ok = 0;
   int          txn_in_frame = 0;
   int          cyc_n = 0, last_rise = 0;

   always @(negedge clk) begin
      txn_t t;
      bit   ack_now;
      cyc_n++;
      ack_now = 0;
      if (!mon_en) begin
         bus.ack = 1'b0;
      end else begin
         if (exp_fd || fd)
            check("frame_done", 32'(fd), 32'(exp_fd));
         if (exp_fd) begin
            check("busy_idle", 32'(busy), 0);
            check("txn_per_frame", txn_in_frame, H * V);
            txn_in_frame = 0;
            chk_b2b = en;
         end else if (chk_b2b) begin
            check("b2b_restart", 32'(bus.stb), 1);
            chk_b2b = 0;
         end
         exp_fd = 0;
         if (bus.stb && !prev_stb) begin
            if (period_ok)
               check("stb_period", cyc_n - last_rise, 4);
            last_rise = cyc_n;
         end
         prev_stb = bus.stb;
         if (bus.stb) begin
            check("cyc_with_stb", 32'(bus.cyc), 1);
            if (waitc == 0) begin
               hold_adr = bus.adr;
               hold_dat = bus.dat_ms;
               case (dly_mode)
                  0:       want = 0;
                  1:       want = 5;
                  default: want = $urandom_range(0, 3);
               endcase
            end else begin
               check("hold_adr", bus.adr, hold_adr);
               check("hold_dat", 32'(bus.dat_ms),
                     32'(hold_dat));
            end
            if (waitc == want) begin
               ack_now = 1;
               waitc = 0;
               n_cmp++;
               if (q.size() == 0) begin
                  n_bad++;
                  $display("FAIL extra_txn: adr 0x%0h, none expected",
                           bus.adr);
               end else begin
                  t = q.pop_front();
                  check("adr", bus.adr, t.adr);
                  check("dat", 32'(bus.dat_ms), 32'(t.dat));
                  txn_in_frame++;
                  exp_fd = t.last;
                  period_ok = (dly_mode == 0) && !t.last;
               end
            end else begin
               waitc++;
            end
         end
         bus.ack = ack_now ||
            (dly_mode == 2 && !bus.stb &&
             $urandom_range(0, 1) == 1);
      end
   end

   // GAP=0 instance: one write per cycle, ack always high
   int k0 = 0;
   bit run0 = 0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus0.stb) begin
            check("g0_adr", bus0.adr, BASE + 2 * k0);
            check("g0_dat", 32'(bus0.dat_ms),
                  32'(ref_pix(2, k0 % H, k0 / H, 0)));
            k0++;
            run0 = 1;
         end else if (run0 && k0 < H * V) begin
            check("g0_stb_continuous", 32'(bus0.stb), 1);
         end
         if (fd0) check("g0_count", k0, H * V);
      end
   end

   task automatic wait_for(input int what, input int target,
                           input string nm);
      bit hit;
      hit = 0;
      for (int i = 0; i < 3000 && !hit; i++) begin
         @(negedge clk);
         case (what)
            0:       hit = busy;
            1:       hit = fd;
            2:       hit = (txn_in_frame >= target);
            3:       hit = bus.stb;
            4:       hit = busy0;
            default: hit = fd0;
         endcase
      end
      n_cmp++;
      if (!hit) begin
         n_bad++;
         $display("FAIL timeout_%s: not reached, required within 3000 cycles",
                  nm);
      end
   endtask

   task automatic one_frame(input int m, input int dm,
                            input int fc);
      dly_mode = dm;
      push_frame(m, fc);
      mode = 2'(m);
      en = 1'b1;
      wait_for(0, 0, "start");
      en = 1'b0;
      wait_for(1, 0, "done");
      repeat (3) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      en0   = 1'b0;
      mode  = 2'd0;
      mode0 = 2'd2;
      repeat (3) @(negedge clk);
      check("rst_cyc", 32'(bus.cyc), 0);
      check("rst_stb", 32'(bus.stb), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_fd", 32'(fd), 0);
      check("rst_adr", bus.adr, BASE);
      check("rst_dat", 32'(bus.dat_ms), 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("idle_stb", 32'(bus.stb), 0);
      check("idle_busy", 32'(busy), 0);
      check("idle_adr", bus.adr, BASE);

      en = 1'b1;
      wait_for(3, 0, "stb_before_reset");
      en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_stb", 32'(bus.stb), 0);
      check("async_rst_cyc", 32'(bus.cyc), 0);
      check("async_rst_busy", 32'(busy), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      mon_en = 1;

      // Two back-to-back scrolling frames
      dly_mode = 0;
      push_frame(3, 0);
      push_frame(3, 1);
      mode = 2'd3;
      en = 1'b1;
      wait_for(0, 0, "f0_start");
      wait_for(1, 0, "f0_done");
      wait_for(0, 0, "f1_start");
      en = 1'b0;
      wait_for(1, 0, "f1_done");
      repeat (3) @(negedge clk);

      // Mode change and enable drop mid-frame are ignored
      push_frame(0, 2);
      mode = 2'd0;
      en = 1'b1;
      wait_for(0, 0, "m0_start");
      wait_for(2, 10, "m0_pixel10");
      mode = 2'd2;
      en = 1'b0;
      wait_for(1, 0, "m0_done");
      repeat (10) @(negedge clk);
      check("stay_idle_busy", 32'(busy), 0);
      check("stay_idle_stb", 32'(bus.stb), 0);

      one_frame(1, 1, 3);
      one_frame(2, 2, 4);
      check("queue_empty", q.size(), 0);

      en0 = 1'b1;
      wait_for(4, 0, "g0_start");
      en0 = 1'b0;
      wait_for(5, 0, "g0_done");
      repeat (5) @(negedge clk);
      check("g0_total", k0, H * V);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mire_gen.md
Name: mire_gen

Overview:
Parametrised test-pattern generator that writes one full frame of RGB565 pixels into the video framebuffer as a Wishbone master. It is the successor to the fixed-grid pattern writer. It adds a proper ack handshake, configurable throttle gap, four selectable patterns, frame-start control and a frame-done indication. It sits beside the video controller on the framebuffer Wishbone arbiter.

Parameters:
HDISP, 640, active pixels per line; must be a multiple of 8
VDISP, 480, active lines per frame
GRID, 16, grid/checker pitch in pixels; power of two, >=2
GAP, 63, idle cycles inserted after each ack (fair-play throttle); 0 allowed
BASE_ADDR, 0, byte address of pixel (0,0)
ADR_W, 32, Wishbone address width

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
enable  in  1  level; frame generation is allowed to start while high
mode  in  2  pattern select: 0 grid, 1 colour bars, 2 checker, 3 scrolling grid
wshb_adr  out  ADR_W  byte address
wshb_dat_ms  out  16  pixel data, RGB565
wshb_cyc  out  1  bus cycle
wshb_stb  out  1  strobe
wshb_we  out  1  constant 1
wshb_sel  out  2  constant 2'b11
wshb_cti  out  3  constant 0 (classic)
wshb_bte  out  2  constant 0
wshb_ack  in  1  slave acknowledge
busy  out  1  high from frame start until the last ack
frame_done  out  1  one-cycle pulse the cycle after the last pixel ack

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; x=y=0; frame_cnt=0; cyc=stb=busy=frame_done=0; adr=BASE_ADDR; dat_ms=0. cyc and stb fall immediately on reset assertion, even mid-transaction.
- FSM states:
  - IDLE: if enable=1, latch mode into mode_q, load pixel (0,0) and go to REQ on the next cycle.
  - REQ: cyc=stb=1; adr and dat_ms are registered and held stable until ack.
  - On ack in REQ:
    - last pixel (x=HDISP-1, y=VDISP-1): go to IDLE; frame_done=1 for one cycle; frame_cnt+1 (wraps mod 2^16); x=y=0.
    - else if GAP>0: go to GAP, with cyc=stb=0.
    - else (GAP=0): stay in REQ with the next pixel's adr/dat on the following cycle; stb stays high.
  - GAP: count GAP cycles, then go to REQ with the next pixel loaded.
  - Pixel period with 0-wait ack is therefore GAP+1 cycles.
- Pixel advance: x increments; at HDISP-1, x=0 and y increments; at VDISP-1, y=0.
- Address: adr = BASE_ADDR + 2*(HDISP*y + x), computed incrementally (+2 per pixel), with no multiplier in the critical path.
- Pattern, computed for the pixel being loaded (W=16'hFFFF, K=16'h0000):
  - mode 0: W if x%GRID==0 or y%GRID==0, else K.
  - mode 1: 8 vertical bars of HDISP/8 pixels each, in order FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. Bar index comes from a bar counter, no divider.
  - mode 2: W if bit log2(GRID) of x XOR the same bit of y equals 1, else K.
  - mode 3: W if (x+frame_cnt)%GRID==0 or y%GRID==0, else K. The vertical lines shift left by one pixel per frame.
- Control sampling:
  - mode is sampled only at frame start; mode changes mid-frame are ignored.
  - enable is sampled only in IDLE. Deasserting enable mid-frame lets the current frame complete, then the block stays in IDLE.
- busy=1 in REQ and GAP.
- Back-to-back frames: with enable held high, the block passes through IDLE for exactly one cycle between frames.
- ack is ignored outside REQ.

Test Plan:
Use HDISP=8, VDISP=4, GRID=4, GAP=3, BASE_ADDR=0x100 unless stated.
1. Reset: hold rst_n=0, then release with enable=0 -> cyc=stb=busy=frame_done=0, adr=0x100 and stays idle; assert rst_n=0 mid-REQ -> cyc/stb drop in the same cycle.
2. Mode 0, ack returned on the first stb cycle:
   - pixel(0,0): adr=0x100, dat=FFFF; pixel(1,1): adr=0x112, dat=0000; pixel(4,2): dat=FFFF.
   - consecutive stb rises are 4 cycles apart; 32 transactions total; frame_done pulses once after ack #32.
3. Ack delayed 5 cycles -> stb/cyc held high 5 cycles with adr/dat unchanged; GAP=0 build with immediate ack -> stb continuously high and adr increments by 2 every cycle.
4. Mode 1 -> line 0 data sequence is FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000, identical on every line.
5. Mode 3, enable held high for 2 frames -> frame 0 pixel(4,1)=FFFF; frame 1 pixel(3,1)=FFFF and pixel(4,1)=0000; one IDLE cycle between frames.
6. Change mode 0->2 and drop enable at pixel 10 -> frame finishes entirely in mode 0, frame_done pulses, block stays IDLE with busy=0.
